// File: rtl/gps_gen_pkg.sv
// gps_gen_pkg
// Constants shared by the GPS signal generator blocks: code and nav-bit timing
// and the telemetry-word preamble, plus a helper that picks one preamble bit.
// No ports.
package gps_gen_pkg;

    localparam int          GC_OVERSAMPLED_LENGTH = 16368;
    localparam int          NAV_BIT_CODE_PERIODS  = 20;
    localparam int          NAV_BIT_PERIOD        = NAV_BIT_CODE_PERIODS * GC_OVERSAMPLED_LENGTH;
    localparam logic [7:0]  NAV_PREAMBLE          = 8'h8B;

    // Preamble bit at position idx, counting from the MSB (idx 0 -> bit 7).
    function automatic logic preamble_bit(input logic [2:0] idx);
        return NAV_PREAMBLE[3'd7 - idx];
    endfunction

endpackage

// File: rtl/nav_msg_feeder_if.sv
// nav_msg_feeder_if
// Byte valid/ready handshake feeding nav_msg_feeder.
//   data_in        : message byte, MSB transmitted first
//   data_valid_in  : byte offered by the producer
//   data_ready_out : feeder can accept a byte this cycle
// Modports: master (producer side), slave (feeder side).
interface nav_msg_feeder_if;
    logic [7:0] data_in;
    logic       data_valid_in;
    logic       data_ready_out;

    modport master (output data_in, output data_valid_in, input data_ready_out);
    modport slave  (input data_in, input data_valid_in, output data_ready_out);
endinterface

// File: rtl/nav_msg_feeder_byte_fifo.sv
// byte_fifo
// Synchronous 8-bit FIFO, DEPTH entries (power of two, >= 2). The head byte is
// presented combinationally on dout; push when full and pop when empty are ignored.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset (empties the FIFO)
//   push, din     : write request and data
//   pop, dout     : read request and head-of-queue data
//   full, empty   : status
//   level         : number of stored bytes
module byte_fifo #(
    parameter int DEPTH    = 4,
    parameter int NB_LEVEL = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push,
    input  logic [7:0]          din,
    input  logic                pop,
    output logic [7:0]          dout,
    output logic                full,
    output logic                empty,
    output logic [NB_LEVEL-1:0] level
);
    localparam int PW = $clog2(DEPTH);

    logic [7:0]          mem_r [DEPTH];
    logic [PW-1:0]       wr_ptr_r;
    logic [PW-1:0]       rd_ptr_r;
    logic [NB_LEVEL-1:0] level_r;
    logic                push_s;
    logic                pop_s;

    assign push_s = push && !full;
    assign pop_s  = pop && !empty;
    assign full   = (level_r == NB_LEVEL'(DEPTH));
    assign empty  = (level_r == {NB_LEVEL{1'b0}});
    assign level  = level_r;
    assign dout   = mem_r[rd_ptr_r];

    // Storage array; contents are don't-care while the pointers say empty.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers and level; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            level_r  <= {NB_LEVEL{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + NB_LEVEL'(1);
                2'b01:   level_r <= level_r - NB_LEVEL'(1);
                default: level_r <= level_r;
            endcase
        end
    end

endmodule

// File: rtl/nav_msg_feeder.sv
// nav_msg_feeder
// Buffers navigation-message bytes and serialises them MSB-first onto msg_out,
// one bit per BIT_PERIOD enabled cycles, aligned with gps_gen_core's message
// counter (both count ena_in cycles from the same reset).
// Ports:
//   clk_in, rst_in_n  : clock, asynchronous active-low reset
//   ena_in            : sample enable shared with gps_gen_core
//   feed (slave)      : byte valid/ready handshake (data_in/data_valid_in/data_ready_out)
//   clr_underrun_in   : clears the sticky underrun flag
//   msg_out           : current nav bit
//   bit_strobe_out    : one-cycle pulse when msg_out takes a new bit
//   underrun_out      : sticky, a bit boundary found no data
//   fifo_level_out    : bytes stored in the FIFO
// Build option: NAV_FEED_PREAMBLE_EN -- idle bits cycle through the 8'h8B
// preamble on underrun instead of sending 0.
module nav_msg_feeder
    import gps_gen_pkg::*;
#(
    parameter int BIT_PERIOD = NAV_BIT_PERIOD,
    parameter int FIFO_DEPTH = 4,
    parameter int NB_LEVEL   = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                clk_in,
    input  logic                rst_in_n,
    input  logic                ena_in,
    nav_msg_feeder_if.slave     feed,
    input  logic                clr_underrun_in,
    output logic                msg_out,
    output logic                bit_strobe_out,
    output logic                underrun_out,
    output logic [NB_LEVEL-1:0] fifo_level_out
);
    localparam int CW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;

    logic [CW-1:0] cnt_r;
    logic [7:0]    shreg_r;
    logic [2:0]    bits_left_r;
    logic          msg_r;
    logic          strobe_r;
    logic          underrun_r;

    logic          boundary_s;
    logic          fifo_full_s;
    logic          fifo_empty_s;
    logic [7:0]    head_s;
    logic          push_s;
    logic          pop_s;
    logic          idle_bit_s;
    logic          underrun_hit_s;
    logic          msg_next_s;
    logic [7:0]    shreg_next_s;
    logic [2:0]    bits_left_next_s;

    assign boundary_s          = ena_in && (cnt_r == CW'(BIT_PERIOD - 1));
    assign feed.data_ready_out = !fifo_full_s;
    assign push_s              = feed.data_valid_in && !fifo_full_s;

    byte_fifo #(
        .DEPTH    (FIFO_DEPTH),
        .NB_LEVEL (NB_LEVEL)
    ) u_fifo (
        .clk   (clk_in),
        .rst_n (rst_in_n),
        .push  (push_s),
        .din   (feed.data_in),
        .pop   (pop_s),
        .dout  (head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .level (fifo_level_out)
    );

`ifdef NAV_FEED_PREAMBLE_EN
    logic [2:0] pre_idx_r;

    // Preamble position: restarts on every byte pop, advances per idle bit sent.
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            pre_idx_r <= 3'd0;
        end else if (pop_s) begin
            pre_idx_r <= 3'd0;
        end else if (underrun_hit_s) begin
            pre_idx_r <= pre_idx_r + 3'd1;
        end else begin
            pre_idx_r <= pre_idx_r;
        end
    end

    assign idle_bit_s = preamble_bit(pre_idx_r);
`else
    assign idle_bit_s = 1'b0;
`endif

    // Boundary decision: shift the current byte, load a new one, or send idle.
    // The FIFO has no bypass, so a byte pushed in this cycle cannot be used here.
    always_comb begin
        msg_next_s       = msg_r;
        shreg_next_s     = shreg_r;
        bits_left_next_s = bits_left_r;
        underrun_hit_s   = 1'b0;
        pop_s            = 1'b0;
        if (boundary_s) begin
            if (bits_left_r != 3'd0) begin
                msg_next_s       = shreg_r[7];
                shreg_next_s     = {shreg_r[6:0], 1'b0};
                bits_left_next_s = bits_left_r - 3'd1;
            end else if (!fifo_empty_s) begin
                pop_s            = 1'b1;
                msg_next_s       = head_s[7];
                shreg_next_s     = {head_s[6:0], 1'b0};
                bits_left_next_s = 3'd7;
            end else begin
                underrun_hit_s   = 1'b1;
                msg_next_s       = idle_bit_s;
            end
        end else begin
            pop_s = 1'b0;
        end
    end

    // Enabled-cycle counter, wraps at BIT_PERIOD-1 like the core's message counter.
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            cnt_r <= {CW{1'b0}};
        end else if (ena_in) begin
            cnt_r <= boundary_s ? {CW{1'b0}} : cnt_r + CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Serialiser state and registered outputs; underrun set beats clear.
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            msg_r       <= 1'b0;
            shreg_r     <= 8'h00;
            bits_left_r <= 3'd0;
            strobe_r    <= 1'b0;
            underrun_r  <= 1'b0;
        end else begin
            msg_r       <= msg_next_s;
            shreg_r     <= shreg_next_s;
            bits_left_r <= bits_left_next_s;
            strobe_r    <= boundary_s;
            if (underrun_hit_s) begin
                underrun_r <= 1'b1;
            end else if (clr_underrun_in) begin
                underrun_r <= 1'b0;
            end else begin
                underrun_r <= underrun_r;
            end
        end
    end

    assign msg_out        = msg_r;
    assign bit_strobe_out = strobe_r;
    assign underrun_out   = underrun_r;

endmodule

// File: tb/tb_nav_msg_feeder.sv
// Self-checking bench for nav_msg_feeder (BIT_PERIOD=16, FIFO_DEPTH=4).
// Reference model: byte queue + pending-bit queue + enabled-cycle count.
module tb_nav_msg_feeder;
    localparam int BP    = 16;
    localparam int DEPTH = 4;
    localparam int NBL   = $clog2(DEPTH + 1);
    localparam int OW    = 4 + NBL;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           ena = 1'b0;
    logic           clr = 1'b0;
    logic           msg;
    logic           strobe;
    logic           under;
    logic [NBL-1:0] level;

    nav_msg_feeder_if bus();

    nav_msg_feeder #(.BIT_PERIOD(BP), .FIFO_DEPTH(DEPTH)) dut (
        .clk_in          (clk),
        .rst_in_n        (rst_n),
        .ena_in          (ena),
        .feed            (bus),
        .clr_underrun_in (clr),
        .msg_out         (msg),
        .bit_strobe_out  (strobe),
        .underrun_out    (under),
        .fifo_level_out  (level)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // reference model state
    logic [7:0] q_fifo[$];
    logic       q_bits[$];
    int         en_cnt;
    logic       m_msg, m_strobe, m_under;
    int         m_pidx;
    logic [7:0] preamble = 8'h8B;
    logic       last_acc;

    logic [OW-1:0] obs_v, exp_v;

    task automatic model_clear();
        q_fifo.delete();
        q_bits.delete();
        en_cnt = 0; m_msg = 1'b0; m_strobe = 1'b0; m_under = 1'b0; m_pidx = 0;
    endtask

    // One clock: drive inputs, advance model by the rules, sample outputs #1 later.
    task automatic cycle(input logic v, input logic [7:0] d, input logic e, input logic c);
        logic acc, hit;
        logic [7:0] b;
        bus.data_in = d; bus.data_valid_in = v; ena = e; clr = c;
        @(posedge clk);
        cyc++;
        acc = v && (q_fifo.size() != DEPTH);
        hit = 1'b0;
        m_strobe = 1'b0;
        if (e && (en_cnt % BP == BP - 1)) begin
            m_strobe = 1'b1;
            if (q_bits.size() > 0) begin
                m_msg = q_bits.pop_front();
            end else if (q_fifo.size() > 0) begin
                b = q_fifo.pop_front();
                m_msg = b[7];
                for (int i = 6; i >= 0; i--) q_bits.push_back(b[i]);
                m_pidx = 0;
            end else begin
                hit = 1'b1;
`ifdef NAV_FEED_PREAMBLE_EN
                m_msg = preamble[7 - m_pidx];
                m_pidx = (m_pidx + 1) % 8;
`else
                m_msg = 1'b0;
`endif
            end
        end
        if (acc) q_fifo.push_back(d);
        if (c) m_under = 1'b0;
        if (hit) m_under = 1'b1;
        if (e) en_cnt++;
        last_acc = acc;
        #1;
        obs_v = {msg, strobe, under, bus.data_ready_out, level};
        exp_v = {m_msg, m_strobe, m_under, (q_fifo.size() != DEPTH), NBL'(q_fifo.size())};
        bus.data_valid_in = 1'b0; clr = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_clear();
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.data_in = 8'h00; bus.data_valid_in = 1'b0;
        #1;
        obs_v = {msg, strobe, under, bus.data_ready_out, level};
        total++;
        if (obs_v !== {4'b0001, {NBL{1'b0}}}) begin
            bad++; $display("FAIL reset got=%b want=%b", obs_v, {4'b0001, {NBL{1'b0}}});
        end
        model_clear();
        #1 rst_n = 1'b1;
    endtask

    task automatic test_single_byte();
        int scnt = 0;
        logic [7:0] got = 8'h00;
        logic idle_exp;
        do_reset();
        for (int i = 0; i < 143; i++) begin
            cycle(i == 2, (i == 2) ? 8'hA5 : 8'h00, 1'b1, 1'b0);
            total++;
            if (obs_v !== exp_v) begin bad++; $display("FAIL single_byte cyc=%0d got=%b want=%b", cyc, obs_v, exp_v); end
            if (strobe) begin scnt++; got = {got[6:0], msg}; end
        end
        total++;
        if (scnt !== 8) begin bad++; $display("FAIL strobe_count got=%0d want=8", scnt); end
        total++;
        if (got !== 8'hA5) begin bad++; $display("FAIL serial_byte got=%h want=a5", got); end
        total++;
        if (under !== 1'b0) begin bad++; $display("FAIL no_underrun got=%b want=0", under); end
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
`ifdef NAV_FEED_PREAMBLE_EN
        idle_exp = 1'b1;
`else
        idle_exp = 1'b0;
`endif
        total++;
        if ({under, msg, strobe} !== {1'b1, idle_exp, 1'b1}) begin
            bad++; $display("FAIL ninth_boundary got=%b want=%b", {under, msg, strobe}, {1'b1, idle_exp, 1'b1});
        end
    endtask

    task automatic test_underrun_clear();
        cycle(1'b0, 8'h00, 1'b1, 1'b1);
        total++;
        if (under !== 1'b0) begin bad++; $display("FAIL clr_underrun got=%b want=0", under); end
        for (int i = 0; i < 15; i++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
            total++;
            if (obs_v !== exp_v) begin bad++; $display("FAIL underrun_wait cyc=%0d got=%b want=%b", cyc, obs_v, exp_v); end
        end
        total++;
        if (under !== 1'b1) begin bad++; $display("FAIL underrun_reset got=%b want=1", under); end
        // clear coinciding with underrun boundary: set wins
        for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1, i == 15);
        total++;
        if ({under, strobe} !== 2'b11) begin bad++; $display("FAIL set_wins got=%b want=11", {under, strobe}); end
    endtask

    task automatic test_fifo_full();
        logic [7:0] bytes [5];
        int k = 0;
        int n = 0;
        do_reset();
        for (int i = 0; i < 5; i++) bytes[i] = 8'($urandom);
        while (k < 5 && n < 40) begin
            cycle(1'b1, bytes[k], 1'b1, 1'b0);
            n++;
            if (last_acc) k++;
            total++;
            if (obs_v !== exp_v) begin bad++; $display("FAIL fifo_full cyc=%0d got=%b want=%b", cyc, obs_v, exp_v); end
            if (n == 4) begin
                total++;
                if ({bus.data_ready_out, level} !== {1'b0, NBL'(4)}) begin
                    bad++; $display("FAIL full_ready got=%b want=%b", {bus.data_ready_out, level}, {1'b0, NBL'(4)});
                end
            end
        end
        total++;
        if (k != 5 || n != 17) begin bad++; $display("FAIL fifth_accept got=%0d/%0d want=5/17", k, n); end
        for (int i = 0; i < 200; i++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
            total++;
            if (obs_v !== exp_v) begin bad++; $display("FAIL drain cyc=%0d got=%b want=%b", cyc, obs_v, exp_v); end
        end
    endtask

    task automatic test_push_at_boundary();
        logic [7:0] b;
        b = 8'($urandom) | 8'h80;
        do_reset();
        for (int i = 0; i < 15; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b1, b, 1'b1, 1'b0);
        total++;
        if ({under, strobe, level} !== {2'b11, NBL'(1)}) begin
            bad++; $display("FAIL bnd_push got=%b want=%b", {under, strobe, level}, {2'b11, NBL'(1)});
        end
        for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        total++;
        if ({msg, strobe, level} !== {b[7], 1'b1, NBL'(0)}) begin
            bad++; $display("FAIL bnd_msb got=%b want=%b", {msg, strobe, level}, {b[7], 1'b1, NBL'(0)});
        end
    endtask

    task automatic test_ena_toggle();
        do_reset();
        for (int i = 0; i < 700; i++) begin
            cycle(($urandom % 4) == 0, 8'($urandom), 1'($urandom % 2), 1'b0);
            total++;
            if (obs_v !== exp_v) begin bad++; $display("FAIL ena_toggle cyc=%0d got=%b want=%b", cyc, obs_v, exp_v); end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 1200; i++) begin
            cycle(($urandom % 8) == 0, 8'($urandom), ($urandom % 4) != 0, ($urandom % 20) == 0);
            total++;
            if (obs_v !== exp_v) begin bad++; $display("FAIL random cyc=%0d got=%b want=%b", cyc, obs_v, exp_v); end
        end
    endtask

    task automatic test_reset_mid_byte();
        do_reset();
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, 8'($urandom) | 8'h80, 1'b1, 1'b0);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({msg, strobe, under, bus.data_ready_out, level} !== {4'b0001, {NBL{1'b0}}}) begin
            bad++; $display("FAIL async_reset got=%b want=%b", {msg, strobe, under, bus.data_ready_out, level}, {4'b0001, {NBL{1'b0}}});
        end
        model_clear();
        #1 rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
            total++;
            if (obs_v !== exp_v) begin bad++; $display("FAIL post_reset cyc=%0d got=%b want=%b", cyc, obs_v, exp_v); end
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_underrun_clear();
        test_fifo_full();
        test_push_at_boundary();
        test_ena_toggle();
        test_random();
        test_reset_mid_byte();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
